// File: rtl/weight_stream_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// weight_stream_ctrl: replays a coefficient ROM NUM_PASSES times into an
// ap_fifo port, using a 2-entry skid buffer to absorb the 1-cycle ROM latency.
// Revision 1.0
// ----------------------------------------------------------------------------
module weight_stream_ctrl #(
  parameter int MEM_SIZE   = 288,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1,
  parameter int NUM_PASSES = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  ap_done,
  output logic [ADDR_WIDTH-1:0] weight_address,
  output logic                  weight_ce,
  input  logic [DATA_WIDTH-1:0] weight_q,
  output logic [DATA_WIDTH-1:0] output_V_din,
  input  logic                  output_V_full_n,
  output logic                  output_V_write
);

  localparam int                    PASS_W    = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);
  localparam logic [PASS_W-1:0]     LAST_PASS = PASS_W'(NUM_PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PASS_W-1:0]     pass_q, pass_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            count_q, count_d;
  logic                  push, pop, ce;
  logic [2:0]            credit_used;

  assign push        = inflight_q;
  assign pop         = (count_q != 2'd0) & output_V_full_n;
  assign credit_used = {1'b0, count_q} + {2'b00, inflight_q};
  assign count_d     = count_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pass_d  = pass_q;
    ce      = 1'b0;
    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        pass_d = '0;
        if (ap_start) state_d = S_RUN;
      end
      S_RUN: begin
        // A slot freed by this cycle's pop can be reused by this cycle's read.
        ce = (credit_used <= (3'd1 + {2'b00, pop}));
        if (ce) begin
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            pass_d = pass_q + PASS_W'(1);
            if (pass_q == LAST_PASS) state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!inflight_q && (count_q == 2'd0)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      pass_q     <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pass_q     <= pass_d;
      inflight_q <= ce;
      count_q    <= count_d;
      if (push) begin
        buf_q[wr_ptr_q] <= weight_q;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign ap_idle        = (state_q == S_IDLE);
  assign ap_done        = (state_q == S_DONE);
  assign ap_ready       = (state_q == S_DONE);
  assign weight_ce      = ce;
  assign weight_address = addr_q;
  assign output_V_write = (count_q != 2'd0);
  assign output_V_din   = buf_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_weight_stream_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_weight_stream_ctrl: scoreboard bench for weight_stream_ctrl in an
// 8x2 configuration and a 1x1 configuration.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_weight_stream_ctrl;

  logic clk, rst_n;
  int   total, bad;

  logic        a_start, a_idle, a_ready, a_done, a_ce, a_write, a_full_n;
  logic [2:0]  a_addr;
  logic [15:0] a_q, a_din;
  logic        b_start, b_idle, b_ready, b_done, b_ce, b_write, b_full_n;
  logic [0:0]  b_addr;
  logic [15:0] b_q, b_din;

  logic [15:0] rom_a [8];
  logic [15:0] rom_b_word;
  logic [15:0] exp_q [$];

  weight_stream_ctrl #(.MEM_SIZE(8), .DATA_WIDTH(16), .NUM_PASSES(2)) u_dut_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(a_start), .ap_idle(a_idle),
    .ap_ready(a_ready), .ap_done(a_done), .weight_address(a_addr),
    .weight_ce(a_ce), .weight_q(a_q), .output_V_din(a_din),
    .output_V_full_n(a_full_n), .output_V_write(a_write)
  );

  weight_stream_ctrl #(.MEM_SIZE(1), .DATA_WIDTH(16), .NUM_PASSES(1)) u_dut_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(b_start), .ap_idle(b_idle),
    .ap_ready(b_ready), .ap_done(b_done), .weight_address(b_addr),
    .weight_ce(b_ce), .weight_q(b_q), .output_V_din(b_din),
    .output_V_full_n(b_full_n), .output_V_write(b_write)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM models with one cycle of read latency
  always @(posedge clk) if (a_ce) a_q <= rom_a[a_addr];
  always @(posedge clk) if (b_ce) b_q <= rom_b_word;

  task automatic fill_a(input int passes);
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < 8; i++) exp_q.push_back(rom_a[i]);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({a_idle, a_ready, a_done, a_ce, a_write, a_addr, a_din} !== {1'b1, 4'b0, 3'd0, 16'h0})
      begin bad++; $display("FAIL reset_a: got %h want %h",
        {a_idle, a_ready, a_done, a_ce, a_write, a_addr, a_din}, {1'b1, 4'b0, 3'd0, 16'h0}); end
    total++;
    if ({b_idle, b_ready, b_done, b_ce, b_write, b_addr, b_din} !== {1'b1, 4'b0, 1'b0, 16'h0})
      begin bad++; $display("FAIL reset_b: got %h want %h",
        {b_idle, b_ready, b_done, b_ce, b_write, b_addr, b_din}, {1'b1, 4'b0, 1'b0, 16'h0}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int nwr = 0, ndone = 0;
    logic [15:0] e;
    exp_q.delete();
    fill_a(2);
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      a_start = (c == 0); a_full_n = 1'b1;
      #1;
      if (a_write && a_full_n) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL basic_extra: cycle %0d din %h", c, a_din); end
        else begin
          e = exp_q.pop_front();
          if (a_din !== e || c != 3 + nwr) begin bad++;
            $display("FAIL basic_word%0d: got %h@%0d want %h@%0d", nwr, a_din, c, e, 3 + nwr); end
        end
        nwr++;
      end
      if (a_done) begin
        ndone++; total++;
        if (c != 20 || a_ready !== 1'b1) begin bad++;
          $display("FAIL basic_done: got cycle %0d ready %b want cycle 20 ready 1", c, a_ready); end
      end
      if (c == 20 || c == 21) begin
        total++;
        if (a_idle !== (c == 21)) begin bad++;
          $display("FAIL basic_idle: cycle %0d got %b want %b", c, a_idle, (c == 21)); end
      end
    end
    total++;
    if (nwr != 16 || ndone != 1 || exp_q.size() != 0) begin bad++;
      $display("FAIL basic_count: got writes %0d dones %0d left %0d want 16 1 0", nwr, ndone, exp_q.size()); end
  endtask

  task automatic test_toggle();
    int nwr = 0, ndone = 0, issued = 0;
    logic prev_stall = 1'b0;
    logic [15:0] prev_din = '0, e;
    exp_q.delete();
    fill_a(2);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      a_start = (c == 0); a_full_n = (c % 2 == 0);
      #1;
      if (prev_stall) begin
        total++;
        if (a_write !== 1'b1 || a_din !== prev_din) begin bad++;
          $display("FAIL toggle_hold: got %b/%h want 1/%h", a_write, a_din, prev_din); end
      end
      total++;
      if (issued - nwr > 2) begin bad++;
        $display("FAIL toggle_occupancy: got %0d want <=2", issued - nwr); end
      if (a_ce) begin
        total++;
        if (a_addr !== 3'(issued % 8)) begin bad++;
          $display("FAIL toggle_addr: got %0d want %0d", a_addr, issued % 8); end
        issued++;
      end
      if (a_write && a_full_n) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL toggle_extra: din %h", a_din); end
        else begin
          e = exp_q.pop_front();
          if (a_din !== e) begin bad++; $display("FAIL toggle_word%0d: got %h want %h", nwr, a_din, e); end
        end
        nwr++;
      end
      if (a_done) ndone++;
      prev_stall = a_write && !a_full_n;
      prev_din   = a_din;
    end
    total++;
    if (nwr != 16 || ndone != 1 || issued != 16) begin bad++;
      $display("FAIL toggle_count: got w%0d d%0d r%0d want 16 1 16", nwr, ndone, issued); end
  endtask

  task automatic test_full_stall();
    int nwr = 0, ndone = 0, issued = 0;
    logic [15:0] e;
    exp_q.delete();
    fill_a(2);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      a_start = (c == 0); a_full_n = (c >= 20);
      #1;
      if (a_ce) begin
        total++;
        if (a_addr !== 3'(issued % 8)) begin bad++;
          $display("FAIL stall_addr: got %0d want %0d", a_addr, issued % 8); end
        issued++;
      end
      if (c == 19) begin
        total++;
        if (issued != 2 || a_write !== 1'b1 || a_din !== rom_a[0]) begin bad++;
          $display("FAIL stall_hold: got reads %0d write %b din %h want 2 1 %h", issued, a_write, a_din, rom_a[0]); end
      end
      if (a_write && a_full_n) begin
        total++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        if (a_din !== e || c != 20 + nwr) begin bad++;
          $display("FAIL stall_word%0d: got %h@%0d want %h@%0d", nwr, a_din, c, e, 20 + nwr); end
        nwr++;
      end
      if (a_done) begin
        ndone++; total++;
        if (c != 37) begin bad++; $display("FAIL stall_done: got cycle %0d want 37", c); end
      end
    end
    total++;
    if (nwr != 16 || ndone != 1) begin bad++;
      $display("FAIL stall_count: got w%0d d%0d want 16 1", nwr, ndone); end
  endtask

  task automatic test_back_to_back();
    int nwr = 0, ndone = 0, want;
    logic [15:0] e;
    exp_q.delete();
    fill_a(2);
    fill_a(2);
    for (int c = 0; c < 55; c++) begin
      @(negedge clk);
      a_start = (c <= 21) || (c == 25) || (c == 30); a_full_n = 1'b1;
      #1;
      if (c == 21) begin
        total++;
        if (a_idle !== 1'b1) begin bad++; $display("FAIL b2b_gap_idle: got %b want 1", a_idle); end
      end
      if (c == 22) begin
        total++;
        if (a_ce !== 1'b1 || a_addr !== 3'd0) begin bad++;
          $display("FAIL b2b_restart: got ce %b addr %0d want 1 0", a_ce, a_addr); end
      end
      if (c >= 42) begin
        total++;
        if (a_ce !== 1'b0 || a_idle !== 1'b1) begin bad++;
          $display("FAIL b2b_extra_run: cycle %0d got ce %b idle %b want 0 1", c, a_ce, a_idle); end
      end
      if (a_write && a_full_n) begin
        total++;
        want = (nwr < 16) ? 3 + nwr : 8 + nwr;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        if (a_din !== e || c != want) begin bad++;
          $display("FAIL b2b_word%0d: got %h@%0d want %h@%0d", nwr, a_din, c, e, want); end
        nwr++;
      end
      if (a_done) begin
        ndone++; total++;
        if (c != 20 && c != 41) begin bad++; $display("FAIL b2b_done: got cycle %0d want 20 or 41", c); end
      end
    end
    total++;
    if (nwr != 32 || ndone != 2) begin bad++;
      $display("FAIL b2b_count: got w%0d d%0d want 32 2", nwr, ndone); end
  endtask

  task automatic test_async_reset();
    int nwr = 0;
    logic hit = 1'b0;
    logic [15:0] e;
    exp_q.delete();
    fill_a(2);
    for (int c = 0; c < 30 && !hit; c++) begin
      @(negedge clk);
      a_start = (c == 0); a_full_n = 1'b1;
      #1;
      if (a_write && a_full_n) begin
        total++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        if (a_din !== e) begin bad++; $display("FAIL areset_word%0d: got %h want %h", nwr, a_din, e); end
        if (nwr == 13) begin
          hit = 1'b1;
          #2 rst_n = 1'b0;
          #1;
          total++;
          if ({a_idle, a_ready, a_done, a_ce, a_write, a_addr, a_din} !== {1'b1, 4'b0, 3'd0, 16'h0})
            begin bad++; $display("FAIL areset_outputs: got %h want %h",
              {a_idle, a_ready, a_done, a_ce, a_write, a_addr, a_din}, {1'b1, 4'b0, 3'd0, 16'h0}); end
        end
        nwr++;
      end
      if (a_done) begin
        total++; bad++;
        $display("FAIL areset_done: got done at cycle %0d want none", c);
      end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL areset_reach: got %0d words want 14", nwr); end
    @(negedge clk);
    rst_n = 1'b1;
    test_basic();
  endtask

  task automatic test_single();
    int nwr = 0, ndone = 0, issued = 0;
    logic [15:0] e;
    exp_q.delete();
    exp_q.push_back(rom_b_word);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      b_start = (c == 0); b_full_n = 1'b1;
      #1;
      if (b_ce) begin
        total++;
        if (b_addr !== 1'b0 || c != 1) begin bad++;
          $display("FAIL single_read: got addr %0d@%0d want 0@1", b_addr, c); end
        issued++;
      end
      if (b_write && b_full_n) begin
        total++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        if (b_din !== e || c != 3) begin bad++;
          $display("FAIL single_word: got %h@%0d want %h@3", b_din, c, e); end
        nwr++;
      end
      if (b_done) begin
        ndone++; total++;
        if (c != 5) begin bad++; $display("FAIL single_done: got cycle %0d want 5", c); end
      end
    end
    total++;
    if (nwr != 1 || ndone != 1 || issued != 1) begin bad++;
      $display("FAIL single_count: got w%0d d%0d r%0d want 1 1 1", nwr, ndone, issued); end
  endtask

  initial begin
    total = 0; bad = 0;
    a_start = 1'b0; a_full_n = 1'b1;
    b_start = 1'b0; b_full_n = 1'b1;
    for (int i = 0; i < 8; i++) rom_a[i] = 16'($urandom) ^ 16'(i * 16'h1111);
    rom_b_word = 16'hBEEF;
    test_reset();
    test_basic();
    test_toggle();
    test_full_stall();
    test_back_to_back();
    test_async_reset();
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
